// File: rtl/hack_loader_pkg.sv
// Shared definitions for the ROM loaders (file-based and UART-based).
// UART_ROM_LOADER_CHECKSUM_EN adds the CHK state used by the trailing checksum byte.
package hack_loader_pkg;

    localparam int DATA_WIDTH = 16;

    // Multi-byte fields on the wire arrive most significant byte first.
    localparam bit HDR_HI_FIRST = 1'b1;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_RST,
        ST_HDR_HI,
        ST_HDR_LO,
        ST_DAT_HI,
        ST_DAT_LO,
        ST_WAIT_RECV,
        ST_WAIT_ACK,
`ifdef UART_ROM_LOADER_CHECKSUM_EN
        ST_CHK,
`endif
        ST_DONE,
        ST_ERR
    } loader_state_e;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_e;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver with a one-entry holding register.
// Reports framing errors (stop bit low) and overruns (byte completes while
// the holding register is still full; the held byte wins).
module uart_rx_byte #(
    parameter int CLKS_PER_BIT = 217
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    input  logic       clear,
    input  logic       consume,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       frame_err,
    output logic       overrun_err
);
    import hack_loader_pkg::*;

    localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] BIT_LOAD  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);

    rx_state_e        state_q, state_d;
    logic             sync1_q, sync1_d, sync2_q, sync2_d, sync3_q, sync3_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       hold_q, hold_d;
    logic             full_q, full_d;
    logic             frame_err_q, frame_err_d;
    logic             overrun_q, overrun_d;

    // State register; the synchroniser resets to the idle (high) line level.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= RX_IDLE;
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            sync3_q     <= 1'b1;
            cnt_q       <= '0;
            idx_q       <= '0;
            shift_q     <= '0;
            hold_q      <= '0;
            full_q      <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            sync3_q     <= sync3_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            shift_q     <= shift_d;
            hold_q      <= hold_d;
            full_q      <= full_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    // Bit timing down-counter, mid-bit sampling and holding-register update.
    always_comb begin
        state_d     = state_q;
        sync1_d     = rx;
        sync2_d     = sync1_q;
        sync3_d     = sync2_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        shift_d     = shift_q;
        hold_d      = hold_q;
        full_d      = full_q & ~consume;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;
        case (state_q)
            RX_IDLE: begin
                if (sync3_q && !sync2_q) begin
                    state_d = RX_START;
                    cnt_d   = HALF_LOAD;
                end
            end
            RX_START: begin
                if (cnt_q == '0) begin
                    if (!sync2_q) begin
                        state_d = RX_DATA;
                        cnt_d   = BIT_LOAD;
                        idx_d   = '0;
                    end else begin
                        state_d = RX_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RX_DATA: begin
                if (cnt_q == '0) begin
                    shift_d = {sync2_q, shift_q[7:1]};
                    cnt_d   = BIT_LOAD;
                    if (idx_q == 3'd7) begin
                        state_d = RX_STOP;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RX_STOP: begin
                if (cnt_q == '0) begin
                    state_d = RX_IDLE;
                    if (!sync2_q) begin
                        frame_err_d = 1'b1;
                    end else if (full_q && !consume) begin
                        overrun_d = 1'b1;
                    end else begin
                        hold_d = shift_q;
                        full_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = RX_IDLE;
        endcase
        if (clear) begin
            full_d = 1'b0;
        end
    end

    assign byte_valid  = full_q;
    assign byte_data   = hold_q;
    assign frame_err   = frame_err_q;
    assign overrun_err = overrun_q;

endmodule

// File: rtl/uart_rom_loader.sv
// Loads a Hack program received over UART into the SoC program ROM.
// Stream: count header (2 bytes), N words (2 bytes each), and with
// UART_ROM_LOADER_CHECKSUM_EN a trailing XOR checksum byte.
//
// state      | meaning
// IDLE       | waiting for run
// RST        | one-cycle rom_loader_reset pulse, counters cleared
// HDR_HI/LO  | collecting the word count N
// DAT_HI/LO  | assembling the next instruction word
// WAIT_RECV  | load held high until the SoC latches the word
// WAIT_ACK   | waiting for the ROM write to complete
// CHK        | comparing the trailing checksum byte (optional)
// DONE       | all words written, done_loading while run
// ERR        | load failed, waits for run to drop
module uart_rom_loader #(
    parameter int CLKS_PER_BIT = 217,
    parameter int DATA_WIDTH   = hack_loader_pkg::DATA_WIDTH,
    parameter int MAX_WORDS    = 32768
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  run,
    input  logic                  uart_rx,
    output logic                  done_loading,
    output logic                  load_error,
    output logic [15:0]           words_loaded,
    output logic                  rom_loader_reset,
    output logic                  rom_loader_load,
    output logic [DATA_WIDTH-1:0] rom_loader_data,
    input  logic                  rom_loader_ack,
    input  logic                  rom_loader_load_received
);
    import hack_loader_pkg::*;

`ifdef UART_ROM_LOADER_CHECKSUM_EN
    localparam loader_state_e END_STATE = ST_CHK;
`else
    localparam loader_state_e END_STATE = ST_DONE;
`endif

    loader_state_e         state_q, state_d;
    logic [15:0]           n_q, n_d, n_new;
    logic [7:0]            hi_q, hi_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  load_q, load_d;
    logic [15:0]           words_q, words_d;
    logic                  err_q, err_d;
`ifdef UART_ROM_LOADER_CHECKSUM_EN
    logic [7:0]            chk_q, chk_d;
`endif

    logic       rx_valid, rx_consume, rx_clear, rx_frame_err, rx_overrun;
    logic [7:0] rx_byte;

    assign rx_clear = !run || (state_q == ST_IDLE);

    uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk        (clk),
        .reset      (reset),
        .rx         (uart_rx),
        .clear      (rx_clear),
        .consume    (rx_consume),
        .byte_valid (rx_valid),
        .byte_data  (rx_byte),
        .frame_err  (rx_frame_err),
        .overrun_err(rx_overrun)
    );

    // Loader state and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            n_q     <= '0;
            hi_q    <= '0;
            data_q  <= '0;
            load_q  <= 1'b0;
            words_q <= '0;
            err_q   <= 1'b0;
`ifdef UART_ROM_LOADER_CHECKSUM_EN
            chk_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            hi_q    <= hi_d;
            data_q  <= data_d;
            load_q  <= load_d;
            words_q <= words_d;
            err_q   <= err_d;
`ifdef UART_ROM_LOADER_CHECKSUM_EN
            chk_q   <= chk_d;
`endif
        end
    end

    // Next-state logic: byte consumption, ROM handshake and run abort.
    always_comb begin
        state_d    = state_q;
        n_d        = n_q;
        hi_d       = hi_q;
        data_d     = data_q;
        load_d     = load_q;
        words_d    = words_q;
        err_d      = err_q | rx_frame_err | rx_overrun;
        rx_consume = 1'b0;
        n_new      = HDR_HI_FIRST ? {n_q[15:8], rx_byte} : {rx_byte, n_q[7:0]};
        case (state_q)
            ST_IDLE: begin
                if (run) state_d = ST_RST;
            end
            ST_RST: begin
                words_d = '0;
                err_d   = 1'b0;
                n_d     = '0;
                state_d = ST_HDR_HI;
            end
            ST_HDR_HI: begin
                if (rx_valid) begin
                    rx_consume = 1'b1;
                    n_d     = HDR_HI_FIRST ? {rx_byte, n_q[7:0]} : {n_q[15:8], rx_byte};
                    state_d = ST_HDR_LO;
                end
            end
            ST_HDR_LO: begin
                if (rx_valid) begin
                    rx_consume = 1'b1;
                    n_d = n_new;
                    if (n_new == '0) begin
                        state_d = END_STATE;
                    end else if (32'(n_new) > MAX_WORDS) begin
                        err_d   = 1'b1;
                        state_d = ST_ERR;
                    end else begin
                        state_d = ST_DAT_HI;
                    end
                end
            end
            ST_DAT_HI: begin
                if (rx_valid) begin
                    rx_consume = 1'b1;
                    hi_d    = rx_byte;
                    state_d = ST_DAT_LO;
                end
            end
            ST_DAT_LO: begin
                if (rx_valid) begin
                    rx_consume = 1'b1;
                    data_d  = DATA_WIDTH'({hi_q, rx_byte});
                    load_d  = 1'b1;
                    state_d = ST_WAIT_RECV;
                end
            end
            ST_WAIT_RECV: begin
                if (rom_loader_load_received) begin
                    load_d  = 1'b0;
                    state_d = ST_WAIT_ACK;
                end
            end
            ST_WAIT_ACK: begin
                if (rom_loader_ack) begin
                    words_d = words_q + 16'd1;
                    state_d = (words_q + 16'd1 == n_q) ? END_STATE : ST_DAT_HI;
                end
            end
`ifdef UART_ROM_LOADER_CHECKSUM_EN
            ST_CHK: begin
                if (rx_valid) begin
                    rx_consume = 1'b1;
                    if (rx_byte == chk_q) begin
                        state_d = ST_DONE;
                    end else begin
                        err_d   = 1'b1;
                        state_d = ST_ERR;
                    end
                end
            end
`endif
            ST_DONE: state_d = ST_DONE;
            ST_ERR:  state_d = ST_ERR;
            default: state_d = ST_IDLE;
        endcase
        if (!run && state_q != ST_IDLE) begin
            rx_consume = 1'b0;
            load_d     = 1'b0;
            state_d    = ST_IDLE;
        end
    end

`ifdef UART_ROM_LOADER_CHECKSUM_EN
    // Running XOR over every header and data byte consumed.
    always_comb begin
        chk_d = chk_q;
        if (state_q == ST_RST) begin
            chk_d = '0;
        end else if (rx_consume) begin
            chk_d = chk_q ^ rx_byte;
        end
    end
`endif

    assign done_loading     = (state_q == ST_DONE) && run;
    assign rom_loader_reset = (state_q == ST_RST);
    assign rom_loader_load  = load_q;
    assign rom_loader_data  = data_q;
    assign words_loaded     = words_q;
    assign load_error       = err_q;

endmodule
